// File: rtl/chan_router_pkg.sv
// Shared types and helpers for the channel router.
package chan_router_pkg;

  typedef enum logic {WR_LOAD = 1'b0, WR_XOR = 1'b1} wr_mode_t;
  typedef enum logic {RD_DIRECT = 1'b0, RD_SCAN = 1'b1} rd_mode_t;

  // Saturating +1 on the low `width` bits; all-ones stays all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned width);
    logic [31:0] max_val;
    max_val = (32'd1 << width) - 32'd1;
    return (cnt == max_val) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/chan_cell.sv
// One router channel: data register plus saturating write counter.
module chan_cell
  import chan_router_pkg::*;
#(
  parameter int unsigned DATA_W = 1,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  wr_mode_t          wr_mode,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  cnt
);

  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;

  // Clear wins over a same-cycle write, dropping it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (clr) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (wr_en) begin
      r_data <= (wr_mode == WR_XOR) ? (r_data ^ din) : din;
      r_cnt  <= CNT_W'(sat_inc(32'(r_cnt), CNT_W));
    end
  end

  assign data = r_data;
  assign cnt  = r_cnt;

endmodule

// File: rtl/chan_router.sv
// Registered N-way write demux into channel cells with a direct/scan read mux.
module chan_router
  import chan_router_pkg::*;
#(
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned DATA_W = 1,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] din,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic              wr_mode,
  input  logic              rd_en,
  input  logic [SEL_W-1:0]  rd_sel,
  input  logic              rd_mode,
  output logic [DATA_W-1:0] dout,
  output logic [SEL_W-1:0]  dout_ch,
  output logic [CNT_W-1:0]  dout_cnt,
  output logic              dout_valid
);

  localparam int unsigned N = 1 << SEL_W;

  logic [N-1:0]      w_wr_en;
  logic [DATA_W-1:0] w_cell_data [N];
  logic [CNT_W-1:0]  w_cell_cnt  [N];
  logic [SEL_W-1:0]  w_rd_ch;
  logic              w_scan_step;

  logic [SEL_W-1:0]  r_scan_ptr;
  logic [DATA_W-1:0] r_dout;
  logic [SEL_W-1:0]  r_dout_ch;
  logic [CNT_W-1:0]  r_dout_cnt;
  logic              r_dout_valid;

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    assign w_wr_en[gi] = in_valid && (wr_sel == SEL_W'(gi));

    chan_cell #(
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .wr_en  (w_wr_en[gi]),
      .din    (din),
      .wr_mode(wr_mode_t'(wr_mode)),
      .data   (w_cell_data[gi]),
      .cnt    (w_cell_cnt[gi])
    );
  end

  assign w_scan_step = rd_en && (rd_mode_t'(rd_mode) == RD_SCAN);
  assign w_rd_ch     = (rd_mode_t'(rd_mode) == RD_SCAN) ? r_scan_ptr : rd_sel;

  // N is a power of two, so the pointer wraps N-1 -> 0 by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_ptr <= '0;
    end else if (w_scan_step) begin
      r_scan_ptr <= r_scan_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= '0;
      r_dout_ch    <= '0;
      r_dout_cnt   <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= rd_en;
      if (rd_en) begin
        r_dout     <= w_cell_data[w_rd_ch];
        r_dout_ch  <= w_rd_ch;
        r_dout_cnt <= w_cell_cnt[w_rd_ch];
      end
    end
  end

  assign dout       = r_dout;
  assign dout_ch    = r_dout_ch;
  assign dout_cnt   = r_dout_cnt;
  assign dout_valid = r_dout_valid;

endmodule

// File: doc/chan_router.md
# chan_router

Parametrised registered demux/mux router: a write port steers input data into one of N channel registers, and a read port returns one channel's contents one cycle later. Each channel keeps a saturating write counter. Two write modes (load, XOR-accumulate) and two read modes (direct select, auto-scan) are supported. The block replaces the fixed 4-way combinational demux-then-mux path in the lab top-levels with a stateful, width-generic router.

## Interface
Parameters:
- SEL_W, 2: select width; channel count N = 2**SEL_W.
- DATA_W, 1: channel data width.
- CNT_W, 4: per-channel write-counter width.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- clr  in  1  synchronous clear of all channel data and counters.
- in_valid  in  1  write strobe.
- din  in  DATA_W  write data.
- wr_sel  in  SEL_W  destination channel.
- wr_mode  in  1  0 = LOAD, 1 = XOR.
- rd_en  in  1  read request.
- rd_sel  in  SEL_W  read channel in DIRECT mode.
- rd_mode  in  1  0 = DIRECT, 1 = SCAN.
- dout  out  DATA_W  registered read data.
- dout_ch  out  SEL_W  channel index that `dout` came from.
- dout_cnt  out  CNT_W  that channel's write count.
- dout_valid  out  1  high for one cycle per accepted read.

## Operation
Writes:
- When `in_valid` is high, channel `wr_sel` is updated.
- LOAD: `ch_data <= din`.
- XOR: `ch_data <= ch_data ^ din`.
- In both modes `ch_cnt` increments and saturates at 2**CNT_W-1 (no wrap).

Clear:
- When `clr` is high, every `ch_data` and `ch_cnt` goes to 0.
- `clr` has priority over a same-cycle write: the write is dropped.
- `clr` does not affect the scan pointer or the output registers.

Read channel selection:
- DIRECT: channel = `rd_sel`.
- SCAN: channel = internal pointer `scan_ptr`.
  - `scan_ptr` advances by 1 on every cycle with `rd_en` high and `rd_mode`=SCAN.
  - It wraps from N-1 to 0.
  - It holds when `rd_mode`=DIRECT.

Read outputs:
- On `rd_en`, `dout`, `dout_ch` and `dout_cnt` load from the selected channel's current (pre-update) state, and `dout_valid` goes to 1.
- Without `rd_en`, `dout_valid` goes to 0 and the data outputs hold their last value.

Same-cycle events:
- A write and a read to the same channel: the read returns the old value and old count; the new value is visible to the next read.
- Switching `rd_mode` DIRECT→SCAN resumes from the held `scan_ptr`.

## Timing
- Write latency: 1 cycle (state visible on the edge after the strobe).
- Read latency: 1 cycle from the `rd_en` edge to `dout_valid`.
- Reads can be issued back-to-back, one per cycle; there is no backpressure.
- Reset (async assert, any time, including mid-scan):
  - All `ch_data`, `ch_cnt` and `scan_ptr` = 0.
  - `dout` = 0, `dout_ch` = 0, `dout_cnt` = 0, `dout_valid` = 0.
- First write or read is accepted on the first rising edge after `rst_n` is released.
- Counter saturation check is width-exact: an increment at all-ones keeps all-ones.

## Structure
- Package `chan_router_pkg`:
  - `wr_mode_t` {WR_LOAD, WR_XOR}.
  - `rd_mode_t` {RD_DIRECT, RD_SCAN}.
  - Helper function for the saturating increment.
- Sub-module `chan_cell` (generated N times) holds one channel's data register and counter. Its inputs are the decoded write enable, `din`, `wr_mode` and `clr`; its outputs are data and count.
- Top level contains:
  - the `wr_sel` → one-hot decoder (demux);
  - `scan_ptr`;
  - the N:1 read mux;
  - the output registers.

## Test plan
Bench configuration: SEL_W=2, DATA_W=4, CNT_W=3.
1. Reset mid-scan: drive SCAN reads to ptr=2, then assert `rst_n`=0 → all outputs 0 immediately. After release, the first SCAN read returns `dout_ch`=0, `dout`=0, `dout_cnt`=0.
2. LOAD/DIRECT: write 0xA to ch1, then 0x5 to ch3 → reading ch1 gives `dout`=0xA, `dout_cnt`=1 with `dout_valid` one cycle after `rd_en`; reading ch3 gives 0x5.
3. XOR + saturation: write 0x3 nine times to ch2 in XOR mode from 0 → `dout`=0x3, `dout_cnt`=7.
4. Same-cycle read/write: ch0 holds 0x1; write 0xF to ch0 while reading ch0 → `dout`=0x1, `dout_cnt`=1; the next read gives 0xF with count 2.
5. SCAN wrap: 6 consecutive SCAN reads → `dout_ch` sequence 0, 1, 2, 3, 0, 1. `rd_en` gaps hold the pointer, and `dout_valid`=0 in each gap cycle.
6. Clear priority: `clr`=1 together with a write of 0x7 to ch3 → a read of ch3 returns `dout`=0, `dout_cnt`=0, and all other channels read 0.
